// File: rtl/fetch_queue_ctrl_if.sv
// Signal bundle between fetch_queue_ctrl and its surroundings: instruction
// memory read port, redirect request and the instruction-queue handshake.
interface fetch_queue_ctrl_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32,
  parameter int DEPTH       = 4
);
  logic                       fetch_en;
  logic [INS_ADDRESS-1:0]     imem_ra;
  logic [INS_W-1:0]           imem_rd;
  logic                       redirect_valid;
  logic [INS_ADDRESS-1:0]     redirect_pc;
  logic                       inst_valid;
  logic                       inst_ready;
  logic [INS_W-1:0]           inst_out;
  logic [INS_ADDRESS-1:0]     inst_pc;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output fetch_en, imem_rd, redirect_valid, redirect_pc, inst_ready,
    input  imem_ra, inst_valid, inst_out, inst_pc, count
  );

  modport slave (
    input  fetch_en, imem_rd, redirect_valid, redirect_pc, inst_ready,
    output imem_ra, inst_valid, inst_out, inst_pc, count
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Sequential instruction fetcher feeding a DEPTH-entry FIFO from a
// combinational instruction memory, with flush-and-restart on redirect.
module fetch_queue_ctrl #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32,
  parameter int DEPTH       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_queue_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = INS_ADDRESS - 2;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  typedef struct packed {
    logic [WW-1:0]    pc_word;
    logic [INS_W-1:0] data;
  } entry_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_pc_word;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  entry_t        r_mem [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  entry_t        w_head;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.inst_ready;
  assign w_head  = r_mem[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.fetch_en) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (!bus.fetch_en) w_state_nxt = S_IDLE;
        w_push = bus.fetch_en & ~bus.redirect_valid &
                 ((r_count < CW'(DEPTH)) | w_pop);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_word <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else if (bus.redirect_valid) begin
      r_pc_word <= bus.redirect_pc[INS_ADDRESS-1:2];
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_tail    <= r_tail + 1'b1;
        r_pc_word <= r_pc_word + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: queue storage has no reset; the outputs are gated by occupancy, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{pc_word: r_pc_word, data: bus.imem_rd};
  end

  assign bus.imem_ra    = {r_pc_word, 2'b00};
  assign bus.inst_valid = w_valid;
  assign bus.inst_out   = w_valid ? w_head.data : '0;
  assign bus.inst_pc    = w_valid ? {w_head.pc_word, 2'b00} : '0;
  assign bus.count      = r_count;
endmodule
